multicycle_alu_sequencer: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It sequences the shared ALU, ALU controller, register file and a single shared instruction/data memory port across fetch, decode, execute, memory and writeback cycles. It drives the 2-bit aluOp class into the ALU controller (00 memory/add, 01 bitwise/shift, 10 branch, 11 upper immediate) and gates funct7 for immediate forms. It also handles memory wait-state handshakes, illegal-opcode/bus-timeout traps and a retired-instruction counter.

---
 rtl/multicycle_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_alu_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_sequencer.sv
// Multi-cycle main control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and single memory port, with wait-state timeout and illegal-opcode traps.
module multicycle_alu_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    input  logic             alu_flag,
    input  logic             clear_trap,
    output logic [3:0]       state,
    output logic [1:0]       alu_op,
    output logic             funct7_en,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_ALU_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_UPPER    = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_4     = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // The counter only has to reach MAX_WAIT-1, where the timeout fires.
    localparam int              WAIT_W     = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);
    localparam logic            TIMEOUT_EN = (MAX_WAIT > 0);

    logic [3:0]        state_q,   state_d;
    logic [1:0]        cause_q,   cause_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [WAIT_W-1:0] wait_q,    wait_d;
    logic              retire_s;
    logic              timeout_s;

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

    // Datapath control strobes decoded from the current state.
    always_comb begin
        alu_op    = 2'b00;
        funct7_en = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_4;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
                alu_op    = 2'b01;
                funct7_en = 1'b1;
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
            end
            S_EXEC_I: begin
                alu_op    = 2'b01;
                funct7_en = (funct3 == 3'b101);
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: mem_req = 1'b1;
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_ALU_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_op    = 2'b10;
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                if (alu_flag) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end else begin
                    pc_write = 1'b0;
                    pc_src   = 1'b0;
                end
            end
            S_UPPER: begin
                alu_op    = 2'b11;
                alu_src_b = SRC_B_IMM;
                alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
            end
            S_TRAP: trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

    // Next state, trap cause, retire counting and memory wait tracking.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        instret_d = instret_q;
        retire_s  = 1'b0;
        timeout_s = TIMEOUT_EN && (wait_q == WAIT_LAST) && !mem_ready;
        case (state_q)
            S_IDLE: state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_LUI, OP_AUIPC:   state_d = S_UPPER;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_UPPER: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    retire_s = 1'b1;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH: retire_s = 1'b1;
            S_TRAP: begin
                if (clear_trap) begin
                    state_d = S_IDLE;
                    cause_d = CAUSE_NONE;
                end else begin
                    state_d = S_TRAP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire_s) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
        end else begin
            instret_d = instret_q;
        end

        // Any cycle without an outstanding wait restarts the count at zero.
        if (mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Self-checking bench for multicycle_alu_sequencer: expected state trace is queued as stimulus is
// driven and compared at each falling edge; per-feature tasks check strobes inline.
module tb_multicycle_alu_sequencer;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3;
    localparam logic [3:0] S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7;
    localparam logic [3:0] S_MEM_WR = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_UPPER = 4'd11;
    localparam logic [3:0] S_TRAP = 4'd12;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ready, alu_flag, clear_trap;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    logic [3:0]  state;
    logic [1:0]  alu_op, alu_src_a, alu_src_b, trap_cause;
    logic        funct7_en, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, trap;
    logic [31:0] instret;

    logic [3:0]  state_w;
    logic [1:0]  alu_op_w, alu_src_a_w, alu_src_b_w, trap_cause_w;
    logic        funct7_en_w, mem_req_w, mem_we_w, ir_write_w, pc_write_w, pc_src_w;
    logic        reg_write_w, wb_sel_w, trap_w;
    logic [1:0]  instret_w;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] sb_q[$];

    always #5 clk = ~clk;

    multicycle_alu_sequencer #(.MAX_WAIT(15), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .alu_flag(alu_flag), .clear_trap(clear_trap),
        .state(state), .alu_op(alu_op), .funct7_en(funct7_en), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    // Narrow-counter instance used to observe instret wrap-around.
    multicycle_alu_sequencer #(.MAX_WAIT(0), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .alu_flag(alu_flag), .clear_trap(clear_trap),
        .state(state_w), .alu_op(alu_op_w), .funct7_en(funct7_en_w), .alu_src_a(alu_src_a_w),
        .alu_src_b(alu_src_b_w), .mem_req(mem_req_w), .mem_we(mem_we_w), .ir_write(ir_write_w),
        .pc_write(pc_write_w), .pc_src(pc_src_w), .reg_write(reg_write_w), .wb_sel(wb_sel_w),
        .trap(trap_w), .trap_cause(trap_cause_w), .instret(instret_w)
    );

    // Scoreboard: pop the queued expected state at every falling edge.
    always @(negedge clk) begin : sb_monitor
        logic [3:0] exp_s;
        if (sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            n_cmp++;
            if (state !== exp_s) begin
                n_bad++;
                $display("FAIL state_trace @%0t: got %0d expected %0d", $time, state, exp_s);
            end
        end
    end

    task automatic drv(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic rdy, input logic flg, input logic clr, input logic [3:0] es);
        @(posedge clk);
        #1;
        run = r; opcode = op; funct3 = f3; mem_ready = rdy; alu_flag = flg; clear_trap = clr;
        sb_q.push_back(es);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_flag = 1'b0; clear_trap = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; alu_flag = 1'b1; clear_trap = 1'b0;
        opcode = OP_R; funct3 = 3'b000;
        #12;
        n_cmp++;
        if ({state, alu_op, alu_src_a, alu_src_b, trap_cause} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_regs: got %h expected 000",
                     {state, alu_op, alu_src_a, alu_src_b, trap_cause});
        end
        n_cmp++;
        if ({mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, trap, funct7_en} !== 9'b0
            || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b instret %0d expected 0",
                     {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, trap, funct7_en},
                     instret);
        end
        do_reset();
    endtask

    task automatic test_add();
        do_reset();
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        n_cmp++;
        if ({mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b} !== 11'b1_0_1_1_0_00_00_10) begin
            n_bad++;
            $display("FAIL add_fetch: got %b expected 10110000010",
                     {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        n_cmp++;
        if ({alu_op, alu_src_a, alu_src_b, mem_req} !== 7'b00_01_01_0) begin
            n_bad++;
            $display("FAIL add_decode: got %b expected 0001010", {alu_op, alu_src_a, alu_src_b, mem_req});
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_EXEC_R);
        n_cmp++;
        if ({alu_op, funct7_en, alu_src_a, alu_src_b, reg_write} !== 8'b01_1_10_00_0) begin
            n_bad++;
            $display("FAIL add_exec: got %b expected 01110000", {alu_op, funct7_en, alu_src_a, alu_src_b, reg_write});
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        n_cmp++;
        if ({reg_write, wb_sel, alu_op} !== 4'b1_0_00 || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL add_wb: got %b instret %0d expected 1000 instret 0", {reg_write, wb_sel, alu_op}, instret);
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH);
        n_cmp++;
        if (instret !== 32'd1) begin
            n_bad++;
            $display("FAIL add_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_load_wait();
        int req_cnt;
        do_reset();
        drv(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_IDLE);
        req_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_FETCH);
            req_cnt += int'(mem_req);
        end
        drv(1'b1, OP_LD, 3'b010, 1'b1, 1'b0, 1'b0, S_FETCH);
        req_cnt += int'(mem_req);
        n_cmp++;
        if (req_cnt !== 4) begin
            n_bad++;
            $display("FAIL lw_fetch_req: got %0d expected 4", req_cnt);
        end
        drv(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_ADDR);
        n_cmp++;
        if ({alu_op, alu_src_a, alu_src_b} !== 6'b00_10_01) begin
            n_bad++;
            $display("FAIL lw_addr: got %b expected 001001", {alu_op, alu_src_a, alu_src_b});
        end
        req_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_RD);
            req_cnt += int'(mem_req && !mem_we);
        end
        drv(1'b1, OP_LD, 3'b010, 1'b1, 1'b0, 1'b0, S_MEM_RD);
        req_cnt += int'(mem_req && !mem_we);
        n_cmp++;
        if (req_cnt !== 3) begin
            n_bad++;
            $display("FAIL lw_read_req: got %0d expected 3", req_cnt);
        end
        drv(1'b0, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_WB);
        n_cmp++;
        if ({reg_write, wb_sel, mem_req} !== 3'b110) begin
            n_bad++;
            $display("FAIL lw_wb: got %b expected 110", {reg_write, wb_sel, mem_req});
        end
        drv(1'b0, OP_LD, 3'b010, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (instret !== 32'd1) begin
            n_bad++;
            $display("FAIL lw_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drv(1'b1, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_BR, 3'b000, 1'b0, 1'b1, 1'b0, S_BRANCH);
        n_cmp++;
        if ({pc_write, pc_src, alu_op, alu_src_a, alu_src_b} !== 8'b1_1_10_10_00) begin
            n_bad++;
            $display("FAIL beq_taken: got %b expected 11101000", {pc_write, pc_src, alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b1, OP_BR, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b0, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, S_BRANCH);
        n_cmp++;
        if ({pc_write, pc_src, alu_op} !== 4'b0_0_10) begin
            n_bad++;
            $display("FAIL beq_not_taken: got %b expected 0010", {pc_write, pc_src, alu_op});
        end
        drv(1'b0, OP_BR, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (instret !== 32'd2) begin
            n_bad++;
            $display("FAIL beq_instret: got %0d expected 2", instret);
        end
    endtask

    task automatic test_imm_upper();
        do_reset();
        drv(1'b1, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_I, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, S_EXEC_I);
        n_cmp++;
        if ({funct7_en, alu_op, alu_src_a, alu_src_b} !== 7'b0_01_10_01) begin
            n_bad++;
            $display("FAIL addi_exec: got %b expected 0011001", {funct7_en, alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b1, OP_I, 3'b000, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        drv(1'b1, OP_I, 3'b101, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_I, 3'b101, 1'b1, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_I, 3'b101, 1'b0, 1'b0, 1'b0, S_EXEC_I);
        n_cmp++;
        if (funct7_en !== 1'b1) begin
            n_bad++;
            $display("FAIL srai_funct7: got %b expected 1", funct7_en);
        end
        drv(1'b1, OP_I, 3'b101, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        drv(1'b1, OP_LUI, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, S_UPPER);
        n_cmp++;
        if ({alu_op, alu_src_a, alu_src_b} !== 6'b11_11_01) begin
            n_bad++;
            $display("FAIL lui_upper: got %b expected 111101", {alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b1, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        drv(1'b1, OP_AUIPC, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, S_UPPER);
        n_cmp++;
        if ({alu_op, alu_src_a, alu_src_b} !== 6'b11_01_01) begin
            n_bad++;
            $display("FAIL auipc_upper: got %b expected 110101", {alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b0, OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        drv(1'b0, OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (instret !== 32'd4) begin
            n_bad++;
            $display("FAIL imm_instret: got %0d expected 4", instret);
        end
    endtask

    task automatic test_traps();
        int req_cnt;
        do_reset();
        drv(1'b1, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_BAD, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_BAD, 3'b000, 1'b1, 1'b1, 1'b0, S_TRAP);
        n_cmp++;
        if ({trap, trap_cause} !== 3'b1_01 ||
            {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, funct7_en,
             alu_op, alu_src_a, alu_src_b} !== 14'b0) begin
            n_bad++;
            $display("FAIL illegal_trap: got trap %b cause %b strobes %b expected 1 01 0", trap, trap_cause,
                     {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, funct7_en,
                      alu_op, alu_src_a, alu_src_b});
        end
        drv(1'b1, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, S_TRAP);
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if ({trap, trap_cause} !== 3'b0_00) begin
            n_bad++;
            $display("FAIL illegal_clear: got %b expected 000", {trap, trap_cause});
        end
        req_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH);
            req_cnt += int'(mem_req);
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_TRAP);
        n_cmp++;
        if (req_cnt !== 15 || trap_cause !== 2'b10 || mem_req !== 1'b0 || trap !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_trap: got req %0d cause %b mem_req %b trap %b expected 15 10 0 1",
                     req_cnt, trap_cause, mem_req, trap);
        end
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, S_TRAP);
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (trap_cause !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b expected 00", trap_cause);
        end
        for (int i = 0; i < 14; i++) begin
            drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_FETCH);
        end
        drv(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        n_cmp++;
        if (trap !== 1'b0 || trap_cause !== 2'b00) begin
            n_bad++;
            $display("FAIL ready_last_cycle: got trap %b cause %b expected 0 00", trap, trap_cause);
        end
    endtask

    task automatic test_stop_and_reset();
        do_reset();
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_EXEC_R);
        drv(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_ALU_WB);
        drv(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (instret !== 32'd1 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_run: got instret %0d mem_req %b expected 1 0", instret, mem_req);
        end

        do_reset();
        drv(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, S_IDLE);
        drv(1'b1, OP_ST, 3'b010, 1'b1, 1'b0, 1'b0, S_FETCH);
        drv(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, S_DECODE);
        drv(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_ADDR);
        drv(1'b1, OP_ST, 3'b010, 1'b0, 1'b0, 1'b0, S_MEM_WR);
        n_cmp++;
        if ({mem_req, mem_we} !== 2'b11) begin
            n_bad++;
            $display("FAIL store_req: got %b expected 11", {mem_req, mem_we});
        end
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (state !== S_IDLE || mem_req !== 1'b0 || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_store: got state %0d mem_req %b instret %0d expected 0 0 0",
                     state, mem_req, instret);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        drv(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_IDLE);
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_FETCH);
            if (k == 3) begin
                n_cmp++;
                if (instret_w !== 2'b11) begin
                    n_bad++;
                    $display("FAIL wrap_preload: got %b expected 11", instret_w);
                end
            end
            drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_DECODE);
            drv(1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_EXEC_R);
            drv((k < 3) ? 1'b1 : 1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b0, S_ALU_WB);
        end
        drv(1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b0, S_IDLE);
        n_cmp++;
        if (instret_w !== 2'b00 || instret !== 32'd4) begin
            n_bad++;
            $display("FAIL wrap_retire: got narrow %b wide %0d expected 00 4", instret_w, instret);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_imm_upper();
        test_traps();
        test_stop_and_reset();
        test_wrap();
        @(posedge clk);
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
